// File: rtl/ulpi_rx_packetizer.sv
// rtl/ulpi_rx_packetizer.sv - ULPI receive-side USB packet framer and PID/length/CRC checker
module ulpi_rx_packetizer #(
    parameter int MAX_LEN = 1027,
    parameter int LEN_W   = 11
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       data,
    input  logic             data_valid,
    input  logic [7:0]       rx_cmd,
    output logic [7:0]       pkt_data,
    output logic             pkt_valid,
    output logic             pkt_first,
    output logic             pkt_eop,
    output logic [2:0]       pkt_status,
    output logic [3:0]       pkt_pid,
    output logic [LEN_W-1:0] pkt_len
);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_LEN + 1);

    localparam logic [2:0] ST_OK    = 3'd0;
    localparam logic [2:0] ST_PID   = 3'd1;
    localparam logic [2:0] ST_CRC   = 3'd2;
    localparam logic [2:0] ST_RXERR = 3'd3;
    localparam logic [2:0] ST_EMPTY = 3'd4;
    localparam logic [2:0] ST_LEN   = 3'd5;
    localparam logic [2:0] ST_LONG  = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_PID, S_BODY, S_END} state_t;
    state_t state, state_nx;

    logic             rx_active, rx_err, rx_active_q;
    logic [7:0]       pid;
    logic [LEN_W-1:0] cnt;
    logic             err_seen;
    logic [4:0]       crc5, crc5_nx;
    logic [15:0]      crc16, crc16_nx;
    logic             in_pkt, fwd;
    logic             len_ok, crc_ok;
    logic [2:0]       status_nx;
    logic             rx_cmd_unused;

    assign rx_active     = (rx_cmd[5:4] == 2'b01) || (rx_cmd[5:4] == 2'b11);
    assign rx_err        = (rx_cmd[5:4] == 2'b11);
    assign rx_cmd_unused = ^{rx_cmd[7:6], rx_cmd[3:0]};

    assign in_pkt = (state == S_PID) || (state == S_BODY);
    assign fwd    = in_pkt && data_valid && (cnt < LEN_MAX);

    // Both CRCs run over every byte after the PID; the PID class picks which one matters.
    always_comb begin
        crc5_nx  = crc5;
        crc16_nx = crc16;
        for (int i = 0; i < 8; i++) begin
            crc5_nx  = (crc5_nx[0] ^ data[i])  ? ((crc5_nx >> 1) ^ 5'h14)     : (crc5_nx >> 1);
            crc16_nx = (crc16_nx[0] ^ data[i]) ? ((crc16_nx >> 1) ^ 16'hA001) : (crc16_nx >> 1);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (rx_active && !rx_active_q) state_nx = S_PID;
            S_PID:   if (!rx_active) state_nx = S_END;
                     else if (data_valid) state_nx = S_BODY;
            S_BODY:  if (!rx_active) state_nx = S_END;
            S_END:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        len_ok = 1'b1;
        crc_ok = 1'b1;
        case (pid[3:0])
            4'h1, 4'h9, 4'h5, 4'hD, 4'h4: begin
                len_ok = (cnt == LEN_W'(3));
                crc_ok = (crc5 == 5'h06);
            end
            4'h3, 4'hB, 4'h7, 4'hF: begin
                len_ok = (cnt >= LEN_W'(3));
                crc_ok = (crc16 == 16'hB001);
            end
            4'h2, 4'hA, 4'hE, 4'h6: len_ok = (cnt == LEN_W'(1));
            default: ;
        endcase

        if (err_seen)                        status_nx = ST_RXERR;
        else if (cnt == '0)                  status_nx = ST_EMPTY;
        else if (pid[7:4] != ~pid[3:0])      status_nx = ST_PID;
        else if (cnt > LEN_MAX)              status_nx = ST_LONG;
        else if (!len_ok)                    status_nx = ST_LEN;
        else if (!crc_ok)                    status_nx = ST_CRC;
        else                                 status_nx = ST_OK;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_active_q <= 1'b0;
            pid         <= '0;
            cnt         <= '0;
            err_seen    <= 1'b0;
            crc5        <= 5'h1F;
            crc16       <= 16'hFFFF;
            pkt_data    <= '0;
            pkt_valid   <= 1'b0;
            pkt_first   <= 1'b0;
            pkt_eop     <= 1'b0;
            pkt_status  <= '0;
            pkt_pid     <= '0;
            pkt_len     <= '0;
        end else begin
            rx_active_q <= rx_active;
            if (state == S_IDLE) begin
                pid      <= '0;
                cnt      <= '0;
                err_seen <= 1'b0;
                crc5     <= 5'h1F;
                crc16    <= 16'hFFFF;
            end
            if (in_pkt && rx_err) err_seen <= 1'b1;
            if (in_pkt && data_valid) begin
                if (cnt != LEN_SAT) cnt <= cnt + 1'b1;
                if (state == S_PID) begin
                    pid <= data;
                end else begin
                    crc5  <= crc5_nx;
                    crc16 <= crc16_nx;
                end
            end

            pkt_valid <= fwd;
            pkt_first <= fwd && (state == S_PID);
            if (fwd) pkt_data <= data;

            // Registered so the strobe always lands after the final forwarded byte.
            pkt_eop <= (state == S_END);
            if (state == S_END) begin
                pkt_status <= status_nx;
                pkt_pid    <= (cnt == '0) ? 4'h0 : pid[3:0];
                pkt_len    <= cnt;
            end
        end
    end
endmodule

// File: tb/tb_ulpi_rx_packetizer.sv
// tb/tb_ulpi_rx_packetizer.sv - randomized self-checking bench for ulpi_rx_packetizer
module tb_ulpi_rx_packetizer;
    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int EW      = 7 + LEN_W;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [7:0]       data;
    logic             data_valid;
    logic [7:0]       rx_cmd;
    logic [7:0]       pkt_data;
    logic             pkt_valid;
    logic             pkt_first;
    logic             pkt_eop;
    logic [2:0]       pkt_status;
    logic [3:0]       pkt_pid;
    logic [LEN_W-1:0] pkt_len;

    ulpi_rx_packetizer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset_n(reset_n), .data(data), .data_valid(data_valid), .rx_cmd(rx_cmd),
        .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_first(pkt_first), .pkt_eop(pkt_eop),
        .pkt_status(pkt_status), .pkt_pid(pkt_pid), .pkt_len(pkt_len)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int eop_seen = 0;
    int eop_pushed = 0;
    int pv_seen = 0;
    logic [8:0]    exp_bq[$];
    logic [EW-1:0] exp_eq[$];
    logic [8:0]    eb;
    logic [EW-1:0] ee;
    logic [7:0]    pbuf[0:15];
    int            plen;

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic b);
        return (c[0] ^ b) ? ((c >> 1) ^ 5'h14) : (c >> 1);
    endfunction

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        return (c[0] ^ b) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    endfunction

    function automatic logic [4:0] crc5_bytes(input int n);
        logic [4:0] c = 5'h1F;
        for (int i = 1; i < n; i++)
            for (int b = 0; b < 8; b++) c = crc5_step(c, pbuf[i][b]);
        return c;
    endfunction

    function automatic logic [15:0] crc16_bytes(input int n);
        logic [15:0] c = 16'hFFFF;
        for (int i = 1; i < n; i++)
            for (int b = 0; b < 8; b++) c = crc16_step(c, pbuf[i][b]);
        return c;
    endfunction

    // Reference status from the packet's bytes alone, in priority order.
    function automatic logic [2:0] model_status(input int n, input bit err);
        logic [3:0] p;
        if (err) return 3'd3;
        if (n == 0) return 3'd4;
        p = pbuf[0][3:0];
        if (pbuf[0][7:4] != ~p) return 3'd1;
        if (n > MAX_LEN) return 3'd6;
        if (p inside {4'h1, 4'h9, 4'h5, 4'hD, 4'h4}) begin
            if (n != 3) return 3'd5;
            if (crc5_bytes(n) != 5'h06) return 3'd2;
        end else if (p inside {4'h3, 4'hB, 4'h7, 4'hF}) begin
            if (n < 3) return 3'd5;
            if (crc16_bytes(n) != 16'hB001) return 3'd2;
        end else if (p inside {4'h2, 4'hA, 4'hE, 4'h6}) begin
            if (n != 1) return 3'd5;
        end
        return 3'd0;
    endfunction

    function automatic logic [7:0] mk_cmd(input logic [1:0] ev);
        logic [7:0] r;
        r = 8'($urandom);
        r[5:4] = ev;
        return r;
    endfunction

    function automatic logic [7:0] idle_cmd();
        return mk_cmd({1'($urandom), 1'b0});
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expect(input logic [2:0] st, input logic [3:0] pid, input logic [LEN_W-1:0] len);
        for (int i = 0; i < plen && i < MAX_LEN; i++) exp_bq.push_back({i == 0, pbuf[i]});
        exp_eq.push_back({st, pid, len});
        eop_pushed++;
    endtask

    task automatic send(input bit err, input bit drop_with, input bit gaps);
        int err_idx;
        err_idx = (plen > 0) ? int'($urandom_range(0, plen - 1)) : 0;
        rx_cmd = mk_cmd(2'b01); data_valid = 1'($urandom); data = 8'($urandom);
        step();
        if (err && plen == 0) begin rx_cmd = mk_cmd(2'b11); data_valid = 1'b0; step(); end
        for (int i = 0; i < plen; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin rx_cmd = mk_cmd(2'b01); data_valid = 1'b0; step(); end
            if (err && i == err_idx) begin rx_cmd = mk_cmd(2'b11); data_valid = 1'b0; step(); end
            data = pbuf[i]; data_valid = 1'b1;
            rx_cmd = (drop_with && i == plen - 1) ? idle_cmd() : mk_cmd(2'b01);
            step();
        end
        if (!(drop_with && plen > 0)) begin rx_cmd = idle_cmd(); data_valid = 1'b0; step(); end
        rx_cmd = idle_cmd(); data_valid = 1'b0;
    endtask

    task automatic wait_eop(input string name);
        int t = 0;
        while (eop_seen != eop_pushed && t < 20) begin
            data_valid = 1'($urandom); data = 8'($urandom); rx_cmd = idle_cmd();
            step();
            t++;
        end
        data_valid = 1'b0;
        chk(eop_seen == eop_pushed, {name, "_eop_arrived"}, eop_seen, eop_pushed);
        chk(exp_bq.size() == 0, {name, "_bytes_drained"}, exp_bq.size(), 0);
        if (eop_seen != eop_pushed || exp_bq.size() != 0) begin
            exp_bq.delete(); exp_eq.delete(); eop_pushed = eop_seen;
        end
        repeat (2) step();
    endtask

    task automatic directed(input string name, input logic [2:0] st, input logic [3:0] pid,
                            input logic [LEN_W-1:0] len, input bit err);
        logic [2:0] ms;
        ms = model_status(plen, err);
        chk(ms == st, {name, "_model"}, ms, st);
        push_expect(st, pid, len);
        send(err, 1'b0, 1'b0);
        wait_eop(name);
    endtask

    task automatic set3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input int n);
        pbuf[0] = a; pbuf[1] = b; pbuf[2] = c; plen = n;
    endtask

    task automatic check_outputs_zero(input string name);
        chk(pkt_valid == 1'b0, {name, "_valid"}, pkt_valid, 0);
        chk(pkt_first == 1'b0, {name, "_first"}, pkt_first, 0);
        chk(pkt_data == 8'h00, {name, "_data"}, pkt_data, 0);
        chk(pkt_eop == 1'b0, {name, "_eop"}, pkt_eop, 0);
        chk(pkt_status == 3'd0, {name, "_status"}, pkt_status, 0);
        chk(pkt_pid == 4'd0, {name, "_pid"}, pkt_pid, 0);
        chk(pkt_len == '0, {name, "_len"}, pkt_len, 0);
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (pkt_valid) begin
                pv_seen++;
                chk(exp_bq.size() != 0, "byte_expected", pkt_data, 0);
                if (exp_bq.size() != 0) begin
                    eb = exp_bq.pop_front();
                    chk({pkt_first, pkt_data} == eb, "byte_first_data", {pkt_first, pkt_data}, eb);
                end
            end
            if (pkt_eop) begin
                eop_seen++;
                chk(!pkt_valid && exp_bq.size() == 0, "eop_after_last_byte", exp_bq.size(), 0);
                chk(exp_eq.size() != 0, "eop_expected", pkt_status, 0);
                if (exp_eq.size() != 0) begin
                    ee = exp_eq.pop_front();
                    chk({pkt_status, pkt_pid, pkt_len} == ee, "eop_status_pid_len",
                        {pkt_status, pkt_pid, pkt_len}, ee);
                end
            end
        end
    end

    initial begin
        logic [3:0]  p;
        logic [10:0] v;
        logic [4:0]  c5;
        logic [15:0] c16;
        int          kind, pl, pv0, s;
        logic [3:0]  toks[5] = '{4'h1, 4'h9, 4'h5, 4'hD, 4'h4};
        logic [3:0]  dats[4] = '{4'h3, 4'hB, 4'h7, 4'hF};
        logic [3:0]  hnds[4] = '{4'h2, 4'hA, 4'hE, 4'h6};

        reset_n = 1'b0; data = '0; data_valid = 1'b0; rx_cmd = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        reset_n = 1'b1;
        repeat (2) step();

        set3(8'hD2, 8'h00, 8'h00, 1); directed("ack", 3'd0, 4'h2, 4'd1, 1'b0);
        set3(8'hC3, 8'h00, 8'h00, 3); directed("data0_ok", 3'd0, 4'h3, 4'd3, 1'b0);
        set3(8'hC3, 8'h00, 8'h01, 3); directed("data0_crc", 3'd2, 4'h3, 4'd3, 1'b0);
        set3(8'hC4, 8'h00, 8'h00, 3); directed("bad_pid", 3'd1, 4'h4, 4'd3, 1'b0);
        set3(8'h69, 8'h00, 8'h10, 3); directed("in_ok", 3'd0, 4'h9, 4'd3, 1'b0);
        set3(8'h69, 8'h00, 8'h10, 2); directed("in_trunc", 3'd5, 4'h9, 4'd2, 1'b0);
        set3(8'h00, 8'h00, 8'h00, 0); directed("empty", 3'd4, 4'h0, 4'd0, 1'b0);
        set3(8'h4B, 8'h01, 8'h02, 3); directed("rxerr", 3'd3, 4'hB, 4'd3, 1'b1);

        pbuf[0] = 8'h4B;
        for (int i = 1; i < 12; i++) pbuf[i] = 8'($urandom);
        plen = 12;
        pv0 = pv_seen;
        directed("long", 3'd6, 4'hB, 4'd9, 1'b0);
        chk(pv_seen - pv0 == 8, "long_valid_count", pv_seen - pv0, 8);

        // Reset in the middle of a packet: bytes already forwarded stand, no eop follows.
        set3(8'h4B, 8'h11, 8'h22, 3);
        for (int i = 0; i < 3; i++) exp_bq.push_back({i == 0, pbuf[i]});
        rx_cmd = mk_cmd(2'b01); data_valid = 1'b0; step();
        for (int i = 0; i < 3; i++) begin data = pbuf[i]; data_valid = 1'b1; step(); end
        data_valid = 1'b0; step();
        chk(exp_bq.size() == 0, "pre_reset_bytes", exp_bq.size(), 0);
        reset_n = 1'b0;
        @(negedge clk);
        check_outputs_zero("mid_reset");
        rx_cmd = idle_cmd();
        @(negedge clk);
        reset_n = 1'b1;
        s = eop_seen;
        repeat (10) step();
        chk(eop_seen == s, "no_eop_after_reset", eop_seen, s);

        for (int n = 0; n < 200; n++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: begin
                    p = toks[$urandom_range(0, 4)];
                    v = 11'($urandom);
                    c5 = 5'h1F;
                    for (int b = 0; b < 11; b++) c5 = crc5_step(c5, v[b]);
                    c5 = ~c5;
                    pbuf[0] = {~p, p}; pbuf[1] = v[7:0]; pbuf[2] = {c5, v[10:8]}; plen = 3;
                end
                1: begin
                    p = dats[$urandom_range(0, 3)];
                    pl = $urandom_range(0, 7);
                    pbuf[0] = {~p, p};
                    for (int i = 1; i <= pl; i++) pbuf[i] = 8'($urandom);
                    c16 = 16'hFFFF;
                    for (int i = 1; i <= pl; i++)
                        for (int b = 0; b < 8; b++) c16 = crc16_step(c16, pbuf[i][b]);
                    c16 = ~c16;
                    pbuf[pl + 1] = c16[7:0]; pbuf[pl + 2] = c16[15:8]; plen = pl + 3;
                end
                2: begin
                    p = hnds[$urandom_range(0, 3)];
                    pbuf[0] = {~p, p}; plen = 1;
                end
                default: begin
                    plen = $urandom_range(0, 12);
                    for (int i = 0; i < plen; i++) pbuf[i] = 8'($urandom);
                    p = 4'($urandom);
                    if ($urandom_range(0, 1) == 1) pbuf[0] = {~p, p};
                end
            endcase
            if (plen > 0 && $urandom_range(0, 3) == 0) begin
                pl = $urandom_range(0, plen - 1);
                pbuf[pl] = pbuf[pl] ^ (8'h01 << $urandom_range(0, 7));
            end
            if ($urandom_range(0, 7) == 0) begin
                if (plen > 0 && $urandom_range(0, 1) == 1) plen--;
                else begin pbuf[plen] = 8'($urandom); plen++; end
            end
            s = ($urandom_range(0, 7) == 0) ? 1 : 0;
            push_expect(model_status(plen, s == 1), (plen == 0) ? 4'h0 : pbuf[0][3:0],
                        (plen > MAX_LEN) ? LEN_W'(MAX_LEN + 1) : LEN_W'(plen));
            send(s == 1, 1'($urandom), 1'($urandom));
            wait_eop("rand");
        end

        chk(exp_eq.size() == 0, "final_eop_queue", exp_eq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
